// File: rtl/des_pkg.sv
// des_pkg: DES constants, permutation tables, S-boxes, key-shift schedules,
// the FSM state type and small helper functions used by des_decrypt_core
// and des_f. Build option: define DES_ENCRYPT_EN to add encryption to the core.
package des_pkg;

  localparam int ROUNDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // All tables use DES numbering: entry value 1 means the MSB of the input.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Rotation applied to each 28-bit key half before round r (index r-1).
  localparam logic [1:0] RSH [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] LSH [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Each S-box packed row-major (4 rows x 16 columns), first entry at the MSB.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[5'(i)])];
    return y;
  endfunction

  // Parity bits (DES bits 8, 16, ... 64) are never referenced by PC1.
  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[6'(i)])];
    return y;
  endfunction

  // Row comes from the outer bits, column from the middle four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] b);
    logic [255:0] t;
    int idx;
    t   = SBOX[n];
    idx = int'({b[5], b[0], b[4:1]});
    return t[8'(255 - 4 * idx) -: 4];
  endfunction

  // Rotate one 28-bit key half by 0..2 places, left (encrypt) or right (decrypt).
  function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] sh,
                                        input logic left);
    logic [27:0] y;
    case (sh)
      2'd1:    y = left ? {h[26:0], h[27]}    : {h[0], h[27:1]};
      2'd2:    y = left ? {h[25:0], h[27:26]} : {h[1:0], h[27:2]};
      default: y = h;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_f.sv
// des_f: combinational DES f-function (E expansion, subkey mix, eight
// S-boxes, P permutation).
module des_f
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_subkey,
  output logic [31:0] o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  assign w_x = perm_e(i_r) ^ i_subkey;

  // sbox1 takes the leftmost six bits and drives the leftmost nibble.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
      assign w_s[31 - 4 * gi -: 4] = sbox_lookup(3'(gi), w_x[47 - 6 * gi -: 6]);
    end
  endgenerate

  assign o_f = perm_p(w_s);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative single-DES engine, one Feistel round per clock,
// valid/ready in and out. Decrypts by default; define DES_ENCRYPT_EN to add
// the i_encrypt port which selects the forward (left-rotating) key schedule.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [63:0] i_data,
  input  logic [63:0] i_key,
`ifdef DES_ENCRYPT_EN
  input  logic        i_encrypt,
`endif
  output logic        o_valid,
  input  logic        i_ready,
  output logic [63:0] o_data,
  output logic        o_busy
);

  state_t      r_state;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [4:0]  r_rnd;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_busy;
  logic        w_enc;

  logic [3:0]  w_idx;
  logic [1:0]  w_sh;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;
  logic [47:0] w_subkey;
  logic [31:0] w_f;
  logic [31:0] w_r_next;

`ifdef DES_ENCRYPT_EN
  logic r_enc;

  // Direction is latched with the block so it cannot change mid-computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc <= 1'b0;
    end else if (r_state == ST_IDLE && i_valid) begin
      r_enc <= i_encrypt;
    end
  end

  assign w_enc = r_enc;
`else
  assign w_enc = 1'b0;
`endif

  // Round r uses schedule entry r-1; rnd=16 wraps the 4-bit index to 15.
  assign w_idx    = r_rnd[3:0] - 4'd1;
  assign w_sh     = w_enc ? LSH[w_idx] : RSH[w_idx];
  assign w_c_rot  = rot28(r_c, w_sh, w_enc);
  assign w_d_rot  = rot28(r_d, w_sh, w_enc);
  assign w_subkey = perm_pc2({w_c_rot, w_d_rot});
  assign w_r_next = r_l ^ w_f;

  des_f u_f (
    .i_r      (r_r),
    .i_subkey (w_subkey),
    .o_f      (w_f)
  );

  // Control FSM and datapath: load on accept, 16 rounds, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_rnd   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            {r_l, r_r} <= perm_ip(i_data);
            {r_c, r_d} <= perm_pc1(i_key);
            r_rnd      <= 5'd1;
            r_busy     <= 1'b1;
            r_state    <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_l <= r_r;
          r_r <= w_r_next;
          r_c <= w_c_rot;
          r_d <= w_d_rot;
          if (r_rnd == 5'(ROUNDS)) begin
            // Final swap: output block is R16 || L16 before FP.
            r_data  <= perm_fp({w_r_next, r_r});
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_rnd <= r_rnd + 5'd1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: expected plaintexts are queued at
// accept time and checked by an independent output monitor.
module tb_des_decrypt_core;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K2P = 64'h0F339333EB6C0C72;
  localparam logic [63:0] P2  = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [63:0] i_data = '0;
  logic [63:0] i_key = '0;
  logic        i_encrypt = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic        o_busy;
  logic [63:0] o_data;

  typedef struct {
    logic [63:0] exp;
    bit          chk;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  n_out = 0;

  des_decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_key     (i_key),
`ifdef DES_ENCRYPT_EN
    .i_encrypt (i_encrypt),
`endif
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: one handshake per negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      sb_t e;
      n_out++;
      $display("out %0d: data=%h cycle=%0d", n_out, o_data, cyc);
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk) check("sb_data", o_data, e.exp);
      end
    end
  end

  task automatic present(input logic [63:0] d, input logic [63:0] k, input bit enc);
    i_data    = d;
    i_key     = k;
    i_encrypt = enc;
    i_valid   = 1'b1;
  endtask

  task automatic wait_accept(input logic [63:0] exp, input bit push, input bit chk,
                             output int acc);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (o_ready && i_valid) got = 1'b1;
    end
    check("accept_seen", 64'(got), 64'd1);
    acc = -1;
    if (got) begin
      sb_t e;
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) begin
        e.exp = exp;
        e.chk = chk;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_valid(output int at);
    bit got = 1'b0;
    at = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (o_valid) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    check("valid_seen", 64'(got), 64'd1);
  endtask

  // Run one block to completion with i_ready already high.
  task automatic run_block(input logic [63:0] d, input logic [63:0] k, input logic [63:0] exp);
    int acc;
    int at;
    present(d, k, 1'b0);
    wait_accept(exp, 1'b1, 1'b1, acc);
    i_valid = 1'b0;
    wait_valid(at);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int at;
    int n0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_data", o_data, 64'd0);
    rst     = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;

    // Classic vector with latency measurement
    present(C1, K1, 1'b0);
    wait_accept(P1, 1'b1, 1'b1, acc);
    i_valid = 1'b0;
    check("busy_after_accept", 64'(o_busy), 64'd1);
    check("ready_after_accept", 64'(o_ready), 64'd0);
    wait_valid(at);
    check("latency", 64'(at - acc), 64'd16);
    @(posedge clk);
    #1;
    check("ready_after_hs", 64'(o_ready), 64'd1);
    check("busy_after_hs", 64'(o_busy), 64'd0);

    // Zero ciphertext, then the same key with every parity bit flipped
    run_block(64'd0, K2, P2);
    run_block(64'd0, K2P, P2);

    // Downstream stall for 10 cycles with a competing input offered
    i_ready = 1'b0;
    present(C1, K1, 1'b0);
    wait_accept(P1, 1'b1, 1'b1, acc);
    i_valid = 1'b0;
    wait_valid(at);
    @(posedge clk);
    #1;
    present(64'hFFFF_FFFF_FFFF_FFFF, K2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(o_valid), 64'd1);
      check("stall_data", o_data, P1);
      check("stall_ready", 64'(o_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    n0 = n_out;
    @(posedge clk);
    #1;
    check("stall_one_hs", 64'(n_out - n0), 64'd1);
    check("hs_valid_drop", 64'(o_valid), 64'd0);
    check("hs_ready_back", 64'(o_ready), 64'd1);
    check("hs_data_kept", o_data, P1);
    repeat (3) @(negedge clk);
    check("ignored_not_stored", 64'(o_busy), 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset during round 7, then a clean block
    present(C1, K1, 1'b0);
    wait_accept(P1, 1'b0, 1'b0, acc);
    i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_data", o_data, 64'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_block(64'd0, K2, P2);

    // Back-to-back with i_valid held high
    present(C1, K1, 1'b0);
    wait_accept(P1, 1'b1, 1'b1, acc);
    n0 = n_out;
    present(64'd0, K2, 1'b0);
    wait_accept(P2, 1'b1, 1'b1, acc2);
    i_valid = 1'b0;
    check("b2b_first_out_before_second_in", 64'(n_out - n0), 64'd1);
    check("b2b_gap", 64'(acc2 - acc), 64'd18);
    wait_valid(at);
    @(posedge clk);
    #1;

`ifdef DES_ENCRYPT_EN
    // Encryption of the classic vector
    present(P1, K1, 1'b1);
    wait_accept(C1, 1'b1, 1'b1, acc);
    i_valid = 1'b0;
    wait_valid(at);
    check("enc_latency", 64'(at - acc), 64'd16);
    @(posedge clk);
    #1;

    // Encrypt-then-decrypt round trip
    for (int n = 0; n < 200; n++) begin
      logic [63:0] d;
      logic [63:0] k;
      logic [63:0] ct;
      d = {$urandom, $urandom};
      k = {$urandom, $urandom};
      present(d, k, 1'b1);
      wait_accept(64'd0, 1'b1, 1'b0, acc);
      i_valid = 1'b0;
      wait_valid(at);
      ct = o_data;
      @(posedge clk);
      #1;
      present(ct, k, 1'b0);
      wait_accept(d, 1'b1, 1'b1, acc);
      i_valid = 1'b0;
      wait_valid(at);
      @(posedge clk);
      #1;
    end
`endif

    repeat (20) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
- Iterative single-DES decryption engine; the inverse-direction counterpart of the existing S-box / f-function encryption datapath.
- Accepts one 64-bit ciphertext block and one 64-bit key over a valid/ready handshake.
- Runs 16 Feistel rounds, one per clock, with a reverse (right-rotating) key schedule.
- Returns the 64-bit plaintext over a second valid/ready handshake. Sits between the Wishbone register file and the data FIFO in the crypto user project.

Parameters:
- None. DES widths are fixed by the standard and are held as package constants.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input block and key valid
- o_ready  out  1  core can accept an input block
- i_data  in  64  ciphertext, bit 63 = DES bit 1
- i_key  in  64  key incl. parity bits, bit 63 = DES bit 1; parity bits ignored
- o_valid  out  1  plaintext valid
- i_ready  in  1  downstream accepts plaintext
- o_data  out  64  plaintext, bit 63 = DES bit 1
- o_busy  out  1  high in ROUND or DONE

Behaviour:
- Reset: clock and reset are as already decided (one clock `clk`; `rst` asynchronous, active-high).
  - Asserting `rst` at any time, including mid-round, immediately forces state IDLE.
  - It also clears o_valid=0, o_busy=0, o_data=0, the L/R/C/D registers and the round counter.
  - o_ready=1 after reset.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready at edge T: load L0R0 = IP(i_data), load C0D0 = PC1(i_key), set rnd=1, go to ROUND.
  - i_data and i_key are sampled only on that edge.
- ROUND:
  - o_ready=0; one round per edge, edges T+1..T+16.
  - Before round r, CD is rotated right by RSH[r] = {0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1} (each 28-bit half independently).
  - Subkey = PC2(rotated CD); round r therefore uses encryption subkey K(17-r).
  - Ln = Rn-1; Rn = Ln-1 XOR f(Rn-1, subkey).
  - rnd increments 1..16 with no wrap. On the round-16 edge (T+16), o_data is loaded with FP(R16||L16) and the FSM goes to DONE.
- DONE:
  - o_valid=1; o_data is held stable until i_ready.
  - On o_valid&&i_ready: o_valid drops on that edge and the FSM goes to IDLE.
  - o_data keeps its last value after the handshake.
- Latency: input handshake to o_valid high = 16 clocks.
  - Throughput is one block per ≥18 clocks (no input acceptance during ROUND/DONE).
- i_valid asserted while busy is ignored and is not stored.
- i_ready asserted while not in DONE has no effect.
- All outputs are registered except o_ready, which is decoded from the state register.

Optional Feature:
- Macro: DES_ENCRYPT_EN.
- Defined:
  - Adds port `i_encrypt` (in, 1), sampled with the input handshake.
  - i_encrypt=1 selects encryption: left rotation by LSH[r] = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1} applied before round r, giving subkey K(r).
  - Latency and handshake are identical to decryption.
- Undefined: the port is absent and the core decrypts only.

Decomposition:
- Package `des_pkg`:
  - permutation tables IP, FP, E, P, PC1, PC2 as constant index arrays
  - RSH/LSH shift schedules
  - ROUNDS=16
  - FSM state enum
- Sub-module `des_f`: combinational f-function.
  - E-expansion, subkey XOR, sbox1..sbox8 instances, P permutation.
  - 32-bit R in, 48-bit subkey in, 32-bit out.
- The core instantiates des_f once and reuses it every round.

Test Plan:
- Key 133457799BBCDFF1, i_data 85E813540F0AB405, i_ready=1 -> o_valid rises exactly 16 clocks after the accept edge, o_data 0123456789ABCDEF.
- Key 0E329232EA6D0D73, i_data 0000000000000000 -> o_data 8787878787878787.
  - Same key with parity bits flipped (0F339333EB6C0C72) -> identical o_data.
- i_ready held low 10 cycles after o_valid -> o_valid and o_data stay stable.
  - o_ready stays 0.
  - Second i_valid during this window is ignored.
  - On i_ready, one handshake occurs and o_ready=1 on the next cycle.
- rst pulsed asynchronously (mid-cycle) during round 7 -> outputs clear immediately, o_ready=1.
  - A new block then decrypts correctly with no residue from the aborted block.
- Back-to-back: two blocks driven with i_valid held high -> the second is accepted only after the first o_valid&&i_ready.
  - Both outputs are correct and in order.
- With DES_ENCRYPT_EN: key 133457799BBCDFF1, i_data 0123456789ABCDEF, i_encrypt=1 -> o_data 85E813540F0AB405.
  - Random 200-block encrypt-then-decrypt round trip returns the original data.
